axi_lite_manager: RTL and testbench
===================================

Name: axi_lite_manager

Overview:
- Single-outstanding AXI4-Lite manager; sits directly upstream of our AXI-Lite subordinate and drives its AW/W/B/AR/R channels.
- Takes one command at a time from a simple valid/ready request port, runs the matching AXI-Lite write or read transaction, and returns data and response on a valid/ready response port.
- Used by test harnesses and by control logic that needs register access to subordinates.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDRESS_WIDTH, 4, address bus width in bits.

Ports:
- axi_aclk_in  in  1  clock
- axi_aresetn_in  in  1  asynchronous active-low reset
- cmd_valid_in  in  1  command valid
- cmd_ready_out  out  1  command accepted this cycle when high together with valid
- cmd_write_in  in  1  1 = write, 0 = read
- cmd_addr_in  in  ADDRESS_WIDTH  target address
- cmd_wdata_in  in  DATA_WIDTH  write data
- cmd_wstrb_in  in  DATA_WIDTH/8  write byte strobes
- rsp_valid_out  out  1  response valid
- rsp_ready_in  in  1  response consumed
- rsp_write_out  out  1  response belongs to a write
- rsp_rdata_out  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp_out  out  2  BRESP or RRESP
- axi_awaddr_out  out  ADDRESS_WIDTH;  axi_awprot_out  out  3;  axi_awvalid_out  out  1;  axi_awready_in  in  1
- axi_wdata_out  out  DATA_WIDTH;  axi_wstrb_out  out  DATA_WIDTH/8;  axi_wvalid_out  out  1;  axi_wready_in  in  1
- axi_bresp_in  in  2;  axi_bvalid_in  in  1;  axi_bready_out  out  1
- axi_araddr_out  out  ADDRESS_WIDTH;  axi_arprot_out  out  3;  axi_arvalid_out  out  1;  axi_arready_in  in  1
- axi_rdata_in  in  DATA_WIDTH;  axi_rresp_in  in  2;  axi_rvalid_in  in  1;  axi_rready_out  out  1

Behaviour:
- Reset: single clock, asynchronous active-low reset. While axi_aresetn_in = 0:
  - state = IDLE;
  - all valid/ready outputs 0, except cmd_ready_out, which is high in IDLE only after reset deasserts;
  - all captured address/data/strobe/response registers 0.
- Reset mid-transaction: abandons the transaction immediately; no response is produced.
- FSM states: IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
- IDLE:
  - cmd_ready_out = 1.
  - On cmd_valid_in && cmd_ready_out, capture write, addr, wdata, wstrb.
  - Next state is WRITE if write, else READ_ADDR.
  - Latency: AXI valids assert the cycle after acceptance.
- WRITE:
  - axi_awvalid_out and axi_wvalid_out both assert in the same first cycle.
  - Each channel is tracked independently (aw_done, w_done). A valid deasserts the cycle after its handshake (valid && ready at a clock edge) and never drops before it.
  - AW and W may complete in the same cycle or in either order.
  - When both are done (including the same edge as the last handshake), go to WRITE_RESP.
- WRITE_RESP:
  - axi_bready_out = 1.
  - On axi_bvalid_in, capture bresp and clear rdata to 0, then go to RESPOND.
- READ_ADDR:
  - axi_arvalid_out = 1 until axi_arready_in, then go to READ_DATA.
- READ_DATA:
  - axi_rready_out = 1.
  - On axi_rvalid_in, capture rdata and rresp, then go to RESPOND.
- RESPOND:
  - rsp_valid_out = 1 with stable payload until rsp_ready_in; then go to IDLE.
  - The next command is accepted no earlier than the cycle after the response handshake; no bypass.
- Protection: axi_awprot_out and axi_arprot_out are constant 3'b000.
- Address/data outputs: driven from the captured registers, stable while the corresponding valid is high.
- Responses: SLVERR/DECERR are passed through unchanged. The manager never retries or times out.
- Spurious inputs: axi_bvalid_in or axi_rvalid_in outside their wait states are ignored, since the matching ready is low.
- Ordering: exactly one transaction in flight, so no reordering is possible.

Decomposition:
- Package axi_lite_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - PROT_DEFAULT = 3'b000;
  - the FSM state enum.
- No sub-module. A single FSM with capture registers is the natural size.

Test Plan:
- Write 0xDEADBEEF, addr 0x4, wstrb 0xF; subordinate raises awready/wready together after 2 cycles, bvalid with OKAY next cycle -> AW/W valid for 3 cycles then both drop; rsp_valid with write = 1, resp = 00, rdata = 0.
- Write where awready comes 1 cycle before wready -> awvalid drops first, wvalid stays until its handshake; bready asserts only after both handshakes.
- Read addr 0x8; arready immediate; rvalid after 3 cycles with rdata 0x12345678, OKAY -> rsp_rdata = 0x12345678, write = 0; cmd_ready low throughout.
- Read returning SLVERR, and rsp_ready held low 5 cycles -> rsp_valid stays high with stable resp = 10; IDLE and cmd_ready return the cycle after rsp_ready.
- Assert reset while in WRITE with awvalid high -> all AXI valids 0 asynchronously (same cycle); no rsp_valid; after release, a new read completes normally.
- Back-to-back commands with cmd_valid held high -> second command accepted only after the first response handshake; exactly one transaction in flight.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the manager FSM state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_WRITE_RESP = 3'd2,
    ST_READ_ADDR  = 3'd3,
    ST_READ_DATA  = 3'd4,
    ST_RESPOND    = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_manager.sv
// Single-outstanding AXI4-Lite manager: one command in, one AXI-Lite
// transaction out, one response back. All outputs come straight from flops.
module axi_lite_manager #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                      axi_aclk_in,
  input  logic                      axi_aresetn_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr_in,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_in,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_in,
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic                      rsp_write_out,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_out,
  output logic [1:0]                rsp_resp_out,
  output logic [ADDRESS_WIDTH-1:0]  axi_awaddr_out,
  output logic [2:0]                axi_awprot_out,
  output logic                      axi_awvalid_out,
  input  logic                      axi_awready_in,
  output logic [DATA_WIDTH-1:0]     axi_wdata_out,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb_out,
  output logic                      axi_wvalid_out,
  input  logic                      axi_wready_in,
  input  logic [1:0]                axi_bresp_in,
  input  logic                      axi_bvalid_in,
  output logic                      axi_bready_out,
  output logic [ADDRESS_WIDTH-1:0]  axi_araddr_out,
  output logic [2:0]                axi_arprot_out,
  output logic                      axi_arvalid_out,
  input  logic                      axi_arready_in,
  input  logic [DATA_WIDTH-1:0]     axi_rdata_in,
  input  logic [1:0]                axi_rresp_in,
  input  logic                      axi_rvalid_in,
  output logic                      axi_rready_out
);
  import axi_lite_pkg::*;

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e state_q, state_d;

  logic                     cmd_ready_q, cmd_ready_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]    wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               resp_q, resp_d;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  assign cmd_hs = cmd_valid_in  & cmd_ready_q;
  assign aw_hs  = awvalid_q     & axi_awready_in;
  assign w_hs   = wvalid_q      & axi_wready_in;
  assign b_hs   = bready_q      & axi_bvalid_in;
  assign ar_hs  = arvalid_q     & axi_arready_in;
  assign r_hs   = rready_q      & axi_rvalid_in;
  assign rsp_hs = rsp_valid_q   & rsp_ready_in;

  always_ff @(posedge axi_aclk_in or negedge axi_aresetn_in) begin
    if (!axi_aresetn_in) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (cmd_hs) state_d = cmd_write_in ? ST_WRITE : ST_READ_ADDR;
      // Both channels must be done; either may finish on this very edge.
      ST_WRITE:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WRITE_RESP;
      ST_WRITE_RESP: if (b_hs) state_d = ST_RESPOND;
      ST_READ_ADDR:  if (ar_hs) state_d = ST_READ_DATA;
      ST_READ_DATA:  if (r_hs) state_d = ST_RESPOND;
      ST_RESPOND:    if (rsp_hs) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they appear one
  // cycle after the edge that caused the transition.
  always_comb begin
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;

    if (cmd_hs) begin
      write_d = cmd_write_in;
      addr_d  = cmd_addr_in;
      wdata_d = cmd_wdata_in;
      wstrb_d = cmd_wstrb_in;
    end
    if (b_hs) begin
      resp_d  = axi_bresp_in;
      rdata_d = '0;
    end
    if (r_hs) begin
      resp_d  = axi_rresp_in;
      rdata_d = axi_rdata_in;
    end

    aw_done_d   = (state_d == ST_WRITE) && (aw_done_q || aw_hs);
    w_done_d    = (state_d == ST_WRITE) && (w_done_q || w_hs);
    awvalid_d   = (state_d == ST_WRITE) && !aw_done_d;
    wvalid_d    = (state_d == ST_WRITE) && !w_done_d;
    bready_d    = (state_d == ST_WRITE_RESP);
    arvalid_d   = (state_d == ST_READ_ADDR);
    rready_d    = (state_d == ST_READ_DATA);
    rsp_valid_d = (state_d == ST_RESPOND);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge axi_aclk_in or negedge axi_aresetn_in) begin
    if (!axi_aresetn_in) begin
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready_out   = cmd_ready_q;
  assign rsp_valid_out   = rsp_valid_q;
  assign rsp_write_out   = write_q;
  assign rsp_rdata_out   = rdata_q;
  assign rsp_resp_out    = resp_q;
  assign axi_awaddr_out  = addr_q;
  assign axi_awprot_out  = PROT_DEFAULT;
  assign axi_awvalid_out = awvalid_q;
  assign axi_wdata_out   = wdata_q;
  assign axi_wstrb_out   = wstrb_q;
  assign axi_wvalid_out  = wvalid_q;
  assign axi_bready_out  = bready_q;
  assign axi_araddr_out  = addr_q;
  assign axi_arprot_out  = PROT_DEFAULT;
  assign axi_arvalid_out = arvalid_q;
  assign axi_rready_out  = rready_q;

endmodule

// File: tb/tb_axi_lite_manager.sv
// Bench for axi_lite_manager: a delay-programmable subordinate/consumer model,
// a directed vector table, a reset-abort sequence and a random phase.
module tb_axi_lite_manager;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = DW / 8;
  localparam int TIMEOUT = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_in, cmd_ready_out, cmd_write_in;
  logic [AW-1:0] cmd_addr_in;
  logic [DW-1:0] cmd_wdata_in;
  logic [SW-1:0] cmd_wstrb_in;
  logic          rsp_valid_out, rsp_ready_in, rsp_write_out;
  logic [DW-1:0] rsp_rdata_out;
  logic [1:0]    rsp_resp_out;
  logic [AW-1:0] axi_awaddr_out, axi_araddr_out;
  logic [2:0]    axi_awprot_out, axi_arprot_out;
  logic          axi_awvalid_out, axi_awready_in;
  logic [DW-1:0] axi_wdata_out;
  logic [SW-1:0] axi_wstrb_out;
  logic          axi_wvalid_out, axi_wready_in;
  logic [1:0]    axi_bresp_in;
  logic          axi_bvalid_in, axi_bready_out;
  logic          axi_arvalid_out, axi_arready_in;
  logic [DW-1:0] axi_rdata_in;
  logic [1:0]    axi_rresp_in;
  logic          axi_rvalid_in, axi_rready_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_lite_manager #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .axi_aclk_in(clk), .axi_aresetn_in(rst_n),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_write_in(cmd_write_in), .cmd_addr_in(cmd_addr_in),
    .cmd_wdata_in(cmd_wdata_in), .cmd_wstrb_in(cmd_wstrb_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_write_out(rsp_write_out), .rsp_rdata_out(rsp_rdata_out),
    .rsp_resp_out(rsp_resp_out),
    .axi_awaddr_out(axi_awaddr_out), .axi_awprot_out(axi_awprot_out),
    .axi_awvalid_out(axi_awvalid_out), .axi_awready_in(axi_awready_in),
    .axi_wdata_out(axi_wdata_out), .axi_wstrb_out(axi_wstrb_out),
    .axi_wvalid_out(axi_wvalid_out), .axi_wready_in(axi_wready_in),
    .axi_bresp_in(axi_bresp_in), .axi_bvalid_in(axi_bvalid_in),
    .axi_bready_out(axi_bready_out),
    .axi_araddr_out(axi_araddr_out), .axi_arprot_out(axi_arprot_out),
    .axi_arvalid_out(axi_arvalid_out), .axi_arready_in(axi_arready_in),
    .axi_rdata_in(axi_rdata_in), .axi_rresp_in(axi_rresp_in),
    .axi_rvalid_in(axi_rvalid_in), .axi_rready_out(axi_rready_out)
  );

  // One command plus subordinate behaviour and the expected response.
  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic [1:0]    sub_resp;
    logic [DW-1:0] sub_rdata;
    bit            exp_write;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [SW-1:0] ws, input int awd, input int wdl, input int bd,
                              input int ard, input int rd, input int rspd, input logic [1:0] sresp,
                              input logic [DW-1:0] srd, input bit ew, input logic [DW-1:0] erd,
                              input logic [1:0] eresp);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = wd; v.wstrb = ws;
    v.aw_dly = awd; v.w_dly = wdl; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd; v.rsp_dly = rspd;
    v.sub_resp = sresp; v.sub_rdata = srd;
    v.exp_write = ew; v.exp_rdata = erd; v.exp_resp = eresp;
    return v;
  endfunction

  // Reference: response is the subordinate's code, rdata only for reads;
  // one cycle to launch, each channel wait adds its delay, one cycle each
  // for the handshake-to-next-phase hops.
  function automatic vec_t rnd_vec();
    vec_t v;
    v.write = 1'($urandom);
    v.addr = AW'($urandom);
    v.wdata = DW'($urandom);
    v.wstrb = SW'($urandom);
    v.aw_dly = int'($urandom_range(4, 0));
    v.w_dly = int'($urandom_range(4, 0));
    v.b_dly = int'($urandom_range(3, 0));
    v.ar_dly = int'($urandom_range(4, 0));
    v.r_dly = int'($urandom_range(4, 0));
    v.rsp_dly = int'($urandom_range(3, 0));
    v.sub_resp = 2'($urandom);
    v.sub_rdata = DW'($urandom);
    v.exp_write = v.write;
    v.exp_rdata = v.write ? '0 : v.sub_rdata;
    v.exp_resp = v.sub_resp;
    return v;
  endfunction

  function automatic int exp_lat(input vec_t v);
    int m;
    m = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    return v.write ? 3 + m + v.b_dly : 3 + v.ar_dly + v.r_dly;
  endfunction

  task automatic drive_cmd(input vec_t v);
    cmd_write_in = v.write;
    cmd_addr_in  = v.addr;
    cmd_wdata_in = v.wdata;
    cmd_wstrb_in = v.wstrb;
  endtask

  task automatic clear_sub();
    axi_awready_in = 1'b0; axi_wready_in = 1'b0; axi_arready_in = 1'b0;
    axi_bvalid_in = 1'b0; axi_bresp_in = 2'b00;
    axi_rvalid_in = 1'b0; axi_rresp_in = 2'b00; axi_rdata_in = '0;
    rsp_ready_in = 1'b0;
  endtask

  // Runs one command end to end; called and returns just after a falling edge.
  task automatic run_txn(input string tag, input vec_t v, input bit hold_next,
                         input vec_t nv, input bit noise);
    int n, wcnt, aw_wait, w_wait, ar_wait, b_wait, r_wait, rsp_wait;
    int first_aw, first_w, first_ar, rsp_lat, aw_cnt, w_cnt, ar_cnt, viol;
    bit accepted, aw_hs, w_hs, ar_hs, b_done, r_done, rsp_done;
    logic          got_write;
    logic [DW-1:0] got_rdata;
    logic [1:0]    got_resp;
    n = 0; wcnt = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; rsp_wait = 0;
    first_aw = 0; first_w = 0; first_ar = 0; rsp_lat = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; viol = 0;
    accepted = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; b_done = 0; r_done = 0; rsp_done = 0;
    got_write = 1'b0; got_rdata = '0; got_resp = 2'b00;

    drive_cmd(v);
    cmd_valid_in = 1'b1;
    while (!accepted && wcnt < TIMEOUT) begin
      if (cmd_ready_out === 1'b1) accepted = 1'b1;
      @(negedge clk);
      wcnt++;
    end
    chk({tag, "_accept"}, 64'(accepted), 64'(1));
    if (!accepted) begin
      cmd_valid_in = 1'b0;
      return;
    end
    if (hold_next) drive_cmd(nv);
    else begin
      cmd_valid_in = 1'b0;
      cmd_write_in = 1'($urandom);
      cmd_addr_in  = AW'($urandom);
    end

    n = 1;
    while (!rsp_done && n < TIMEOUT) begin
      if (cmd_ready_out !== 1'b0) viol++;
      if (axi_awprot_out !== 3'b000 || axi_arprot_out !== 3'b000) viol++;

      if (rsp_valid_out === 1'b1) begin
        if (rsp_lat == 0) begin
          rsp_lat = n; got_write = rsp_write_out; got_rdata = rsp_rdata_out; got_resp = rsp_resp_out;
        end else if (rsp_write_out !== got_write || rsp_rdata_out !== got_rdata ||
                     rsp_resp_out !== got_resp) viol++;
        rsp_ready_in = (rsp_wait >= v.rsp_dly);
        rsp_wait++;
        if (rsp_ready_in) rsp_done = 1'b1;
      end else rsp_ready_in = noise ? 1'($urandom) : 1'b0;

      if (axi_bready_out === 1'b1) begin
        if (!v.write || !(aw_hs && w_hs) || b_done) viol++;
        axi_bvalid_in = (b_wait >= v.b_dly);
        axi_bresp_in = v.sub_resp;
        b_wait++;
        if (axi_bvalid_in) b_done = 1'b1;
      end else begin
        axi_bvalid_in = noise ? 1'($urandom) : 1'b0;
        axi_bresp_in = 2'($urandom);
      end

      if (axi_rready_out === 1'b1) begin
        if (v.write || !ar_hs || r_done) viol++;
        axi_rvalid_in = (r_wait >= v.r_dly);
        axi_rdata_in = v.sub_rdata;
        axi_rresp_in = v.sub_resp;
        r_wait++;
        if (axi_rvalid_in) r_done = 1'b1;
      end else begin
        axi_rvalid_in = noise ? 1'($urandom) : 1'b0;
        axi_rdata_in = DW'($urandom);
        axi_rresp_in = 2'($urandom);
      end

      if (axi_awvalid_out === 1'b1) begin
        if (!v.write || aw_hs || axi_awaddr_out !== v.addr) viol++;
        if (first_aw == 0) first_aw = n;
        axi_awready_in = (aw_wait >= v.aw_dly);
        aw_wait++;
        if (axi_awready_in) begin aw_hs = 1'b1; aw_cnt++; end
      end else begin
        if (first_aw != 0 && !aw_hs) viol++;
        axi_awready_in = noise ? 1'($urandom) : 1'b0;
      end

      if (axi_wvalid_out === 1'b1) begin
        if (!v.write || w_hs || axi_wdata_out !== v.wdata || axi_wstrb_out !== v.wstrb) viol++;
        if (first_w == 0) first_w = n;
        axi_wready_in = (w_wait >= v.w_dly);
        w_wait++;
        if (axi_wready_in) begin w_hs = 1'b1; w_cnt++; end
      end else begin
        if (first_w != 0 && !w_hs) viol++;
        axi_wready_in = noise ? 1'($urandom) : 1'b0;
      end

      if (axi_arvalid_out === 1'b1) begin
        if (v.write || ar_hs || axi_araddr_out !== v.addr) viol++;
        if (first_ar == 0) first_ar = n;
        axi_arready_in = (ar_wait >= v.ar_dly);
        ar_wait++;
        if (axi_arready_in) begin ar_hs = 1'b1; ar_cnt++; end
      end else begin
        if (first_ar != 0 && !ar_hs) viol++;
        axi_arready_in = noise ? 1'($urandom) : 1'b0;
      end

      @(negedge clk);
      n++;
    end
    clear_sub();

    chk({tag, "_rsp_done"}, 64'(rsp_done), 64'(1));
    chk({tag, "_first_aw"}, 64'(first_aw), 64'(v.write ? 1 : 0));
    chk({tag, "_first_w"}, 64'(first_w), 64'(v.write ? 1 : 0));
    chk({tag, "_first_ar"}, 64'(first_ar), 64'(v.write ? 0 : 1));
    chk({tag, "_hs_counts"}, 64'({aw_cnt[7:0], w_cnt[7:0], ar_cnt[7:0]}),
        v.write ? 64'(24'h010100) : 64'(24'h000001));
    chk({tag, "_rsp_latency"}, 64'(rsp_lat), 64'(exp_lat(v)));
    chk({tag, "_rsp_write"}, 64'(got_write), 64'(v.exp_write));
    chk({tag, "_rsp_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
    chk({tag, "_rsp_resp"}, 64'(got_resp), 64'(v.exp_resp));
    chk({tag, "_protocol_violations"}, 64'(viol), 64'(0));
    if (rsp_done) begin
      chk({tag, "_ready_after_rsp"}, 64'({cmd_ready_out, rsp_valid_out}), 64'(2'b10));
    end
  endtask

  vec_t tbl [0:6];
  vec_t cur, nxt, rv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    cmd_valid_in = 1'b0;
    cmd_write_in = 1'b0; cmd_addr_in = '0; cmd_wdata_in = '0; cmd_wstrb_in = '0;
    clear_sub();

    //                wr addr   wdata         strb  aw w b ar r rsp sresp  srdata        ew  erdata        eresp
    tbl[0] = mk(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2, 2, 0, 0, 0, 0, 2'b00, 32'h0,        1'b1, 32'h0,        2'b00);
    tbl[1] = mk(1'b1, 4'hC, 32'hA5A50F0F, 4'h5, 1, 2, 1, 0, 0, 0, 2'b00, 32'h0,        1'b1, 32'h0,        2'b00);
    tbl[2] = mk(1'b0, 4'h8, 32'h0,        4'h0, 0, 0, 0, 0, 3, 0, 2'b00, 32'h12345678, 1'b0, 32'h12345678, 2'b00);
    tbl[3] = mk(1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 2, 0, 5, 2'b10, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 2'b10);
    tbl[4] = mk(1'b1, 4'h6, 32'h01234567, 4'h3, 3, 0, 2, 0, 0, 1, 2'b11, 32'h0,        1'b1, 32'h0,        2'b11);
    tbl[5] = mk(1'b0, 4'hF, 32'h0,        4'h0, 0, 0, 0, 1, 1, 1, 2'b01, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 2'b01);
    tbl[6] = mk(1'b1, 4'h1, 32'h55AA55AA, 4'h8, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        1'b1, 32'h0,        2'b00);

    repeat (3) @(negedge clk);
    chk("reset_handshake_outputs",
        64'({cmd_ready_out, axi_awvalid_out, axi_wvalid_out, axi_bready_out,
             axi_arvalid_out, axi_rready_out, rsp_valid_out}), 64'(0));
    chk("reset_payload_outputs",
        64'({axi_awaddr_out, axi_wstrb_out, rsp_write_out, rsp_resp_out}), 64'(0));
    chk("reset_data_outputs", 64'({axi_wdata_out, rsp_rdata_out}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready_out), 64'(1));

    // Directed table, with cmd_valid held high into the next command.
    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i], (i < 6), tbl[(i < 6) ? i + 1 : i], 1'b0);
    end

    // Reset while a write address is still waiting for awready.
    rv = mk(1'b1, 4'h2, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1'b1, 32'h0, 2'b00);
    drive_cmd(rv);
    cmd_valid_in = 1'b1;
    w = 0;
    while (cmd_ready_out !== 1'b1 && w < TIMEOUT) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid_in = 1'b0;
    @(negedge clk);
    chk("abort_awvalid_before_reset", 64'(axi_awvalid_out), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valids_async",
        64'({axi_awvalid_out, axi_wvalid_out, axi_bready_out, axi_arvalid_out,
             axi_rready_out, rsp_valid_out, cmd_ready_out}), 64'(0));
    repeat (2) @(negedge clk);
    chk("abort_no_rsp_in_reset", 64'({rsp_valid_out, axi_awvalid_out}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_after_release", 64'({cmd_ready_out, axi_awvalid_out, rsp_valid_out}), 64'(3'b100));
    rv = mk(1'b0, 4'h9, 32'h0, 4'h0, 0, 0, 0, 1, 2, 0, 2'b00, 32'h600DCAFE, 1'b0, 32'h600DCAFE, 2'b00);
    run_txn("post_abort_read", rv, 1'b0, rv, 1'b0);

    // Random traffic with spurious inputs outside the wait states.
    cur = rnd_vec();
    for (int i = 0; i < 40; i++) begin
      bit hold;
      nxt = rnd_vec();
      hold = (i < 39) ? 1'($urandom) : 1'b0;
      run_txn($sformatf("rnd%0d", i), cur, hold, nxt, 1'b1);
      cur = nxt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
